// File: rtl/adder_pkg.sv
// adder_pkg: shared definitions for the segmented add/subtract unit.
//   state_t  - FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   nseg_of  - number of segments for a given operand width and segment width
//   idx_w_of - width of the segment index counter (at least 1 bit)
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Guarded against seg_w < 1 so the derivation itself never divides by
  // zero; the top rejects such a parameter set explicitly.
  function automatic int nseg_of(input int width, input int seg_w);
    return (seg_w > 0) ? (width / seg_w) : 1;
  endfunction

  function automatic int idx_w_of(input int nseg);
    return (nseg > 1) ? $clog2(nseg) : 1;
  endfunction

endpackage

// File: rtl/seq_adder_nbit_seg.sv
// seg_adder: combinational SEG_W-bit ripple-carry slice.
//   x, y : segment operands
//   ci   : carry into the least significant bit
//   s    : segment sum
//   co   : carry out of the most significant bit
module seg_adder #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] x,
  input  logic [SEG_W-1:0] y,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co
);

  logic [SEG_W:0] c;

  assign c[0] = ci;

  for (genvar gi = 0; gi < SEG_W; gi++) begin : g_bit
    assign s[gi]   = x[gi] ^ y[gi] ^ c[gi];
    assign c[gi+1] = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
  end

  assign co = c[SEG_W];

endmodule

// File: rtl/seq_adder_nbit.sv
// seq_adder_nbit: multi-cycle add/subtract unit, one SEG_W-bit segment per
// clock with the carry held in a register between segments.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready : operand handshake for a, b, c_in, sub
//   sub                 : 0 -> a + b + c_in, 1 -> a - b - c_in
//   out_valid/out_ready : result handshake for sum, c_out, overflow, zero
//   c_out               : raw carry out of the MSB (in sub mode 1 = no borrow)
//   overflow            : two's-complement signed overflow
//   zero                : sum == 0
//   busy                : high while computing or holding a result
module seq_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow,
  output logic             zero,
  output logic             busy
);

  localparam int NSEG  = nseg_of(WIDTH, SEG_W);
  localparam int IDX_W = idx_w_of(NSEG);
  localparam int MSB   = WIDTH - 1;

  if (SEG_W < 1) begin : g_bad_seg_w
    $error("seq_adder_nbit: SEG_W must be at least 1");
  end else if ((WIDTH % SEG_W) != 0) begin : g_bad_width
    $error("seq_adder_nbit: WIDTH must be a multiple of SEG_W");
  end

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic              carry_reg;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;      // already inverted for subtraction
  logic [WIDTH-1:0]  acc_reg;    // partial sum, kept off the outputs
  logic [WIDTH-1:0]  sum_reg;
  logic              c_out_reg;
  logic              overflow_reg;
  logic              zero_reg;
  logic              in_ready_reg;
  logic              out_valid_reg;
  logic              busy_reg;

  logic [SEG_W-1:0]  a_seg [NSEG];
  logic [SEG_W-1:0]  b_seg [NSEG];
  logic [WIDTH-1:0]  acc_next;
  logic [SEG_W-1:0]  seg_s;
  logic              seg_co;
  logic              last_seg;
  logic              overflow_next;

  // Segment views of the latched operands, plus the accumulator with the
  // current segment replaced by the slice result.
  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    assign a_seg[gi] = a_reg[gi*SEG_W +: SEG_W];
    assign b_seg[gi] = b_reg[gi*SEG_W +: SEG_W];
    assign acc_next[gi*SEG_W +: SEG_W] =
      (idx_reg == IDX_W'(gi)) ? seg_s : acc_reg[gi*SEG_W +: SEG_W];
  end

  seg_adder #(.SEG_W(SEG_W)) u_seg (
    .x  (a_seg[idx_reg]),
    .y  (b_seg[idx_reg]),
    .ci (carry_reg),
    .s  (seg_s),
    .co (seg_co)
  );

  assign last_seg = (idx_reg == IDX_W'(NSEG - 1));

  // Operands of equal sign producing a result of the other sign. b_reg is
  // the effective addend, so this holds for subtraction as well.
  assign overflow_next = (a_reg[MSB] == b_reg[MSB]) && (acc_next[MSB] != a_reg[MSB]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      idx_reg       <= '0;
      carry_reg     <= 1'b0;
      a_reg         <= '0;
      b_reg         <= '0;
      acc_reg       <= '0;
      sum_reg       <= '0;
      c_out_reg     <= 1'b0;
      overflow_reg  <= 1'b0;
      zero_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            a_reg        <= a;
            b_reg        <= sub ? ~b : b;
            // a - b - c_in == a + ~b + (1 - c_in)
            carry_reg    <= c_in ^ sub;
            idx_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          carry_reg <= seg_co;
          if (last_seg) begin
            sum_reg       <= acc_next;
            c_out_reg     <= seg_co;
            overflow_reg  <= overflow_next;
            zero_reg      <= (acc_next == '0);
            out_valid_reg <= 1'b1;
            idx_reg       <= '0;
            state_reg     <= DONE;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign overflow  = overflow_reg;
  assign zero      = zero_reg;

endmodule

// File: tb/tb_seq_adder_nbit.sv
module tb_seq_adder_nbit;

  localparam int W    = 16;
  localparam int NSEG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rst_aux_n;
  logic         in_valid, in_ready, c_in, sub;
  logic         out_valid, out_ready, c_out, overflow, zero, busy;
  logic [W-1:0] a, b, sum;

  int total = 0;
  int bad   = 0;

  seq_adder_nbit #(.WIDTH(W), .SEG_W(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow),
    .zero      (zero),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         sb;
    logic [W-1:0] s;
    logic         co;
    logic         v;
    logic         z;
  } vec_t;

  vec_t vecs [9];

  // Present one operand set and let the accepting edge pass; inputs are
  // scrambled afterwards so a late-sampling design would be caught.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input logic ts);
    chk("in_ready_at_issue", in_ready, 1);
    a = ta; b = tb_v; c_in = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); c_in = ~tc; sub = ~ts;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int lat;
    issue(v.a, v.b, v.ci, v.sb);
    wait_result(lat);
    chk("latency", lat, NSEG);
    chk("sum", sum, v.s);
    chk("c_out", c_out, v.co);
    chk("overflow", overflow, v.v);
    chk("zero", zero, v.z);
    chk("busy_done", busy, 1);
    chk("in_ready_done", in_ready, 0);
    $display("vec %0d: a=%h b=%h ci=%0d sub=%0d -> sum=%h c=%0d v=%0d z=%0d lat=%0d",
             id, v.a, v.b, v.ci, v.sb, sum, c_out, overflow, zero, lat);
    @(posedge clk); #1;
    chk("drain_out_valid", out_valid, 0);
    chk("drain_in_ready", in_ready, 1);
  endtask

  // Random/corner ops against an arithmetic model on extra configurations,
  // including SEG_W == WIDTH.
  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int GW = (gi == 2) ? 32 : 8;
    localparam int GS = (gi == 0) ? 2 : 8;

    logic          g_in_valid, g_in_ready, g_c_in, g_sub;
    logic          g_out_valid, g_out_ready, g_c_out, g_ovf, g_zero, g_busy;
    logic [GW-1:0] g_a, g_b, g_sum;
    bit            done = 1'b0;

    seq_adder_nbit #(.WIDTH(GW), .SEG_W(GS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_aux_n),
      .in_valid  (g_in_valid),
      .in_ready  (g_in_ready),
      .a         (g_a),
      .b         (g_b),
      .c_in      (g_c_in),
      .sub       (g_sub),
      .out_valid (g_out_valid),
      .out_ready (g_out_ready),
      .sum       (g_sum),
      .c_out     (g_c_out),
      .overflow  (g_ovf),
      .zero      (g_zero),
      .busy      (g_busy)
    );

    initial begin
      logic [GW-1:0] corners [5];
      logic [GW-1:0] ra, rb, e_sum;
      logic          rc, rs, e_c, e_v, e_z;
      longint        ua, ub, lc, full, sa, sb, sr, smax, smin;
      int            lat;
      corners[0] = '0;
      corners[1] = GW'(1);
      corners[2] = {1'b0, {(GW-1){1'b1}}};
      corners[3] = {1'b1, {(GW-1){1'b0}}};
      corners[4] = '1;
      g_in_valid = 1'b0; g_out_ready = 1'b1;
      g_a = '0; g_b = '0; g_c_in = 1'b0; g_sub = 1'b0;
      wait (rst_aux_n === 1'b1);
      @(posedge clk); #1;
      for (int n = 0; n < 400; n++) begin
        if (n < 100) begin
          ra = corners[n % 5]; rb = corners[(n / 5) % 5];
          rc = ((n / 25) % 2) != 0; rs = ((n / 50) % 2) != 0;
        end else begin
          ra = GW'($urandom); rb = GW'($urandom);
          rc = $urandom_range(0, 1) != 0; rs = $urandom_range(0, 1) != 0;
        end
        ua = longint'(ra); ub = longint'(rb); lc = rc ? 64'sd1 : 64'sd0;
        if (!rs) begin
          full = ua + ub + lc;
          e_c  = full[GW];
        end else begin
          full = ua - ub - lc;
          e_c  = (ua >= ub + lc);
        end
        e_sum = full[GW-1:0];
        sa = ra[GW-1] ? ua - (64'sd1 <<< GW) : ua;
        sb = rb[GW-1] ? ub - (64'sd1 <<< GW) : ub;
        sr = rs ? (sa - sb - lc) : (sa + sb + lc);
        smax = (64'sd1 <<< (GW - 1)) - 64'sd1;
        smin = -(64'sd1 <<< (GW - 1));
        e_v = (sr > smax) || (sr < smin);
        e_z = (e_sum == '0);

        g_a = ra; g_b = rb; g_c_in = rc; g_sub = rs; g_in_valid = 1'b1;
        @(posedge clk); #1;
        g_in_valid = 1'b0;
        lat = 0;
        while (!g_out_valid && lat < 100) begin
          @(posedge clk); #1;
          lat++;
        end
        chk("cfg_out_valid", g_out_valid, 1);
        chk("cfg_latency", lat, GW / GS);
        chk("cfg_sum", g_sum, e_sum);
        chk("cfg_c_out", g_c_out, e_c);
        chk("cfg_overflow", g_ovf, e_v);
        chk("cfg_zero", g_zero, e_z);
        $display("cfg W=%0d S=%0d op %0d: a=%h b=%h ci=%0d sub=%0d -> sum=%h c=%0d v=%0d z=%0d",
                 GW, GS, n, ra, rb, rc, rs, g_sum, g_c_out, g_ovf, g_zero);
        @(posedge clk); #1;
      end
      done = 1'b1;
    end
  end

  initial begin : main
    int lat;
    int guard;
    bit leaked;

    vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{16'h0005, 16'h0005, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};

    rst_n = 1'b0; rst_aux_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_sum", sum, 0);
    chk("reset_c_out", c_out, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_zero", zero, 0);
    rst_n = 1'b1; rst_aux_n = 1'b1;
    @(posedge clk); #1;

    // Directed table, issued back to back.
    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Backpressure: result held while out_ready is low, new requests ignored.
    out_ready = 1'b0;
    issue(16'h0F0F, 16'h1111, 1'b0, 1'b0);
    wait_result(lat);
    chk("bp_latency", lat, NSEG);
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2) == 0;
      a = W'($urandom); b = W'($urandom);
      @(posedge clk); #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", sum, 16'h2020);
      chk("bp_busy", busy, 1);
    end
    $display("backpressure: held sum=%h for 10 cycles", sum);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", out_valid, 0);
    chk("bp_release_in_ready", in_ready, 1);
    run_vec('{16'hFFFF, 16'h0002, 1'b0, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0}, 100);

    // Reset while the segment index is 2: outputs clear at once.
    issue(16'h1111, 16'h2222, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sum", sum, 0);
    chk("rst_mid_c_out", c_out, 0);
    chk("rst_mid_out_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    chk("rst_mid_overflow", overflow, 0);
    chk("rst_mid_zero", zero, 0);
    $display("mid-run reset: sum=%h in_ready=%0d", sum, in_ready);
    @(posedge clk); #1;
    rst_n = 1'b1;
    leaked = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) leaked = 1'b1;
    end
    chk("rst_dropped_op", leaked, 0);
    run_vec('{16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1'b0}, 101);

    guard = 0;
    while (!(g_cfg[0].done && g_cfg[1].done && g_cfg[2].done) && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    chk("cfg_all_done", g_cfg[0].done && g_cfg[1].done && g_cfg[2].done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
